// File: rtl/mn_matrix_pkg.sv
// Shared definitions for the mn_matrix storage block and its read sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mn_matrix_pkg;

  localparam int MAX_DIM = 128;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mn_skid_fifo.sv
// Two-entry fall-through FIFO carrying an element plus its last-marker.
// Latency: 0 cycles when empty (input bypasses to the head), else head of queue.
// Backpressure: out_rdy low holds the head stable; the producer must not push into a full FIFO.
module mn_skid_fifo #(
  parameter int DATA_W = mn_matrix_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_last,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_last,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] dat_q [2];
  logic              last_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              stored_vld;
  logic              store;
  logic              deq;

  assign stored_vld = (count != 2'd0);

  // An arriving element consumed in the same cycle through the bypass is never stored.
  assign store = in_vld && !(!stored_vld && out_rdy);
  assign deq   = stored_vld && out_rdy;

  assign out_vld  = stored_vld || in_vld;
  assign out_dat  = stored_vld ? dat_q[rd_ptr]  : (in_vld ? in_dat  : '0);
  assign out_last = stored_vld ? last_q[rd_ptr] : (in_vld && in_last);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (store) wr_ptr <= ~wr_ptr;
      if (deq)   rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, store} - {1'b0, deq};
    end
  end

  // Payload storage; contents are only observed when count says an entry is valid.
  always_ff @(posedge clk) begin
    if (store) begin
      dat_q[wr_ptr]  <= in_dat;
      last_q[wr_ptr] <= in_last;
    end
  end

endmodule

// File: rtl/mn_matrix_reader.sv
// Walks an M x N matrix (or its transpose) in row-major order and streams the elements out.
// Latency: first read one cycle after start, first element one cycle after that, then one per cycle.
// Backpressure: out_ready low stalls reads through a 2-credit window; at most 2 elements buffered.
module mn_matrix_reader #(
  parameter int DATA_W  = mn_matrix_pkg::DATA_W,
  parameter int MAX_DIM = mn_matrix_pkg::MAX_DIM
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             transpose,
  input  logic [mn_matrix_pkg::ADDR_W-1:0] m_dim,
  input  logic [mn_matrix_pkg::ADDR_W-1:0] n_dim,
  output logic                             mem_read,
  output logic [mn_matrix_pkg::ADDR_W-1:0] mem_m_addr,
  output logic [mn_matrix_pkg::ADDR_W-1:0] mem_n_addr,
  output logic                             mem_transpose,
  input  logic [DATA_W-1:0]                mem_data,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  import mn_matrix_pkg::*;

  state_t            state;
  logic [7:0]        row;
  logic [7:0]        col;
  logic [7:0]        last_row;
  logic [7:0]        last_col;
  logic              inflight;
  logic              inflight_last;
  logic [1:0]        fifo_count;
  logic [ADDR_W-1:0] dim_r;
  logic [ADDR_W-1:0] dim_c;
  logic              dim_bad;
  logic              pop;
  logic              issue;
  logic              final_rd;

  // Logical shape of the traversal: transposed walks swap the roles of the dimensions.
  assign dim_r   = transpose ? n_dim : m_dim;
  assign dim_c   = transpose ? m_dim : n_dim;
  assign dim_bad = (dim_r == '0) || (dim_c == '0) ||
                   (dim_r > ADDR_W'(MAX_DIM)) || (dim_c > ADDR_W'(MAX_DIM));

  assign pop = out_valid && out_ready;

  // Outstanding elements (buffered + in flight), less the one leaving now, must stay below 2.
  assign issue = (state == RUN) &&
                 (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  assign final_rd = (row == last_row) && (col == last_col);

  // Counters stop on the final element, so the address ports hold whenever no read issues.
  assign mem_read   = issue;
  assign mem_m_addr = ADDR_W'(row);
  assign mem_n_addr = ADDR_W'(col);
  assign busy       = (state != IDLE);

  // Traversal FSM with row/col counters and the one-deep read-return tracker.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      row           <= 8'd0;
      col           <= 8'd0;
      last_row      <= 8'd0;
      last_col      <= 8'd0;
      mem_transpose <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done          <= 1'b0;
      err           <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && final_rd;
      case (state)
        IDLE: begin
          if (start) begin
            mem_transpose <= transpose;
            if (dim_bad) begin
              err  <= 1'b1;
              done <= 1'b1;
            end else begin
              row      <= 8'd0;
              col      <= 8'd0;
              last_row <= 8'(dim_r - ADDR_W'(1));
              last_col <= 8'(dim_c - ADDR_W'(1));
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (final_rd) begin
              state <= DRAIN;
            end else if (col == last_col) begin
              col <= 8'd0;
              row <= row + 8'd1;
            end else begin
              col <= col + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mn_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (inflight),
    .in_dat   (mem_data),
    .in_last  (inflight_last),
    .out_vld  (out_valid),
    .out_rdy  (out_ready),
    .out_dat  (out_data),
    .out_last (out_last),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_mn_matrix_reader.sv
// Directed bench for mn_matrix_reader with a synchronous-read matrix model.
// Latency: matrix returns data the cycle after mem_read.
// Backpressure: out_ready driven per scenario.
module tb_mn_matrix_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        transpose = 1'b0;
  logic [31:0] m_dim = '0;
  logic [31:0] n_dim = '0;
  logic        mem_read;
  logic [31:0] mem_m_addr;
  logic [31:0] mem_n_addr;
  logic        mem_transpose;
  logic [31:0] mem_data = 32'hDEAD_BEEF;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;

  // Hand-computed tables for the 2x3 matrix holding 10*row+col.
  int p_m[6] = '{0, 0, 0, 1, 1, 1};
  int p_n[6] = '{0, 1, 2, 0, 1, 2};
  int p_d[6] = '{0, 1, 2, 10, 11, 12};
  int t_m[6] = '{0, 0, 1, 1, 2, 2};
  int t_n[6] = '{0, 1, 0, 1, 0, 1};
  int t_d[6] = '{0, 10, 1, 11, 2, 12};
  int bp_d[4] = '{0, 1, 2, 3};
  int r9_d[9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};

  always #5 clk = ~clk;

  mn_matrix_reader #(.DATA_W(32), .MAX_DIM(128)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .transpose     (transpose),
    .m_dim         (m_dim),
    .n_dim         (n_dim),
    .mem_read      (mem_read),
    .mem_m_addr    (mem_m_addr),
    .mem_n_addr    (mem_n_addr),
    .mem_transpose (mem_transpose),
    .mem_data      (mem_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  // Matrix model: stored element (r,c) = 10*r+c, transposed access swaps the indices.
  always @(posedge clk) begin
    if (mem_read)
      mem_data <= mem_transpose ? (32'd10 * mem_n_addr + mem_m_addr)
                                : (32'd10 * mem_m_addr + mem_n_addr);
  end

  // Pulses start for one edge; returns mid-cycle 1.
  task automatic start_job(input int m, input int n, input bit tr);
    @(negedge clk);
    m_dim = m; n_dim = n; transpose = tr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({mem_read, out_valid, out_last, busy, done, err, mem_transpose} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000", {mem_read, out_valid, out_last, busy, done, err, mem_transpose});
    end
    checks++; if (out_data !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h exp 0", out_data);
    end
    checks++; if (mem_m_addr !== 32'd0 || mem_n_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %0d,%0d exp 0,0", mem_m_addr, mem_n_addr);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate(input string nm, input int m, input int n, input bit tr,
                                input int em[6], input int en[6], input int ed[6]);
    out_ready = 1'b1;
    start_job(m, n, tr);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      checks++; if (mem_read !== (k <= 6)) begin
        errors++; $display("FAIL %s rd k=%0d got %b exp %b", nm, k, mem_read, (k <= 6));
      end
      if (k <= 6) begin
        checks++; if (mem_m_addr !== em[k-1] || mem_n_addr !== en[k-1]) begin
          errors++; $display("FAIL %s addr k=%0d got %0d,%0d exp %0d,%0d", nm, k, mem_m_addr, mem_n_addr, em[k-1], en[k-1]);
        end
      end
      checks++; if (out_valid !== (k >= 2 && k <= 7)) begin
        errors++; $display("FAIL %s vld k=%0d got %b", nm, k, out_valid);
      end
      if (k >= 2 && k <= 7) begin
        checks++; if (out_data !== ed[k-2] || out_last !== (k == 7)) begin
          errors++; $display("FAIL %s data k=%0d got %0d/%b exp %0d/%b", nm, k, out_data, out_last, ed[k-2], (k == 7));
        end
      end
      checks++; if (done !== (k == 8) || busy !== (k <= 7) || err !== 1'b0) begin
        errors++; $display("FAIL %s ctl k=%0d got done=%b busy=%b err=%b", nm, k, done, busy, err);
      end
      checks++; if (mem_transpose !== tr) begin
        errors++; $display("FAIL %s mtr k=%0d got %b exp %b", nm, k, mem_transpose, tr);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int rd = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit fin = 1'b0;
    logic [31:0] held = '0;
    logic held_last = 1'b0;
    logic [3:0] pat = 4'b1001;
    out_ready = 1'b1;
    start_job(1, 4, 1'b0);
    while (!fin && cyc < 40) begin
      if (cyc > 0) @(negedge clk);
      out_ready = pat[3 - (cyc % 4)];
      #1;
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_data !== held || out_last !== held_last) begin
          errors++; $display("FAIL bp_stable cyc=%0d got %b/%0d exp 1/%0d", cyc, out_valid, out_data, held);
        end
      end
      if (mem_read === 1'b1) rd++;
      if (out_valid === 1'b1 && out_ready) begin
        checks++; if (acc >= 4) begin
          errors++; $display("FAIL bp_extra got element %0d exp none", out_data);
        end else if (out_data !== bp_d[acc] || out_last !== (acc == 3)) begin
          errors++; $display("FAIL bp_data idx=%0d got %0d/%b exp %0d/%b", acc, out_data, out_last, bp_d[acc], (acc == 3));
        end
        acc++;
      end
      checks++; if (rd - acc > 2) begin
        errors++; $display("FAIL bp_ahead cyc=%0d got %0d exp <=2", cyc, rd - acc);
      end
      stalled = (out_valid === 1'b1) && !out_ready;
      held = out_data;
      held_last = out_last;
      if (done === 1'b1) fin = 1'b1;
      cyc++;
    end
    checks++; if (!fin) begin
      errors++; $display("FAIL bp_timeout got no done exp done within 40 cycles");
    end
    checks++; if (acc != 4 || rd != 4) begin
      errors++; $display("FAIL bp_count got acc=%0d rd=%0d exp 4/4", acc, rd);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_bad_dims();
    int bm[2] = '{0, 2};
    int bn[2] = '{3, 129};
    for (int i = 0; i < 2; i++) begin
      start_job(bm[i], bn[i], 1'b0);
      checks++; if ({err, done, busy, mem_read} !== 4'b1100) begin
        errors++; $display("FAIL bad%0d_c1 got err,done,busy,rd=%b exp 1100", i, {err, done, busy, mem_read});
      end
      @(negedge clk); #1;
      checks++; if ({err, done, busy, mem_read} !== 4'b0000) begin
        errors++; $display("FAIL bad%0d_c2 got err,done,busy,rd=%b exp 0000", i, {err, done, busy, mem_read});
      end
    end
  endtask

  task automatic test_reset_mid();
    int cnt = 0;
    bit fin = 1'b0;
    out_ready = 1'b1;
    start_job(3, 3, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (k >= 2) begin
        checks++; if (out_valid !== 1'b1 || out_data !== r9_d[k-2]) begin
          errors++; $display("FAIL rst_pre k=%0d got %b/%0d exp 1/%0d", k, out_valid, out_data, r9_d[k-2]);
        end
      end
    end
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if ({mem_read, out_valid, out_last, busy, done, err, mem_transpose} !== 7'b0 || out_data !== 32'd0) begin
      errors++; $display("FAIL rst_mid got flags=%b data=%0d exp 0/0", {mem_read, out_valid, out_last, busy, done, err, mem_transpose}, out_data);
    end
    checks++; if (mem_m_addr !== 32'd0 || mem_n_addr !== 32'd0) begin
      errors++; $display("FAIL rst_mid_addr got %0d,%0d exp 0,0", mem_m_addr, mem_n_addr);
    end
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rst_quiet k=%0d got done=%b vld=%b busy=%b exp 0", k, done, out_valid, busy);
      end
    end
    start_job(3, 3, 1'b0);
    checks++; if (mem_read !== 1'b1 || mem_m_addr !== 32'd0 || mem_n_addr !== 32'd0) begin
      errors++; $display("FAIL rst_restart got rd=%b addr=%0d,%0d exp 1/0,0", mem_read, mem_m_addr, mem_n_addr);
    end
    for (int k = 0; k < 30 && !fin; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (out_valid === 1'b1) begin
        checks++; if (cnt >= 9 || out_data !== r9_d[cnt]) begin
          errors++; $display("FAIL rst_redo idx=%0d got %0d", cnt, out_data);
        end
        cnt++;
      end
      if (done === 1'b1) fin = 1'b1;
    end
    checks++; if (!fin || cnt != 9) begin
      errors++; $display("FAIL rst_redo_count got fin=%b cnt=%0d exp 1/9", fin, cnt);
    end
  endtask

  task automatic test_start_ignored();
    int cnt = 0;
    out_ready = 1'b1;
    start_job(2, 3, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) begin @(negedge clk); #1; end
      if (out_valid === 1'b1) begin
        checks++; if (cnt >= 6 || out_data !== p_d[cnt]) begin
          errors++; $display("FAIL ign_data idx=%0d got %0d", cnt, out_data);
        end
        cnt++;
      end
      checks++; if (done !== (k == 8) || mem_transpose !== 1'b0) begin
        errors++; $display("FAIL ign_ctl k=%0d got done=%b mtr=%b", k, done, mem_transpose);
      end
      if (k >= 2 && k <= 4) begin
        m_dim = 1; n_dim = 1; transpose = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0; transpose = 1'b0;
      end
    end
    checks++; if (cnt != 6 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_count got cnt=%0d busy=%b exp 6/0", cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_rate("plain", 2, 3, 1'b0, p_m, p_n, p_d);
    test_full_rate("transpose", 2, 3, 1'b1, t_m, t_n, t_d);
    test_backpressure();
    test_bad_dims();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mn_matrix_reader.md
# mn_matrix_reader

Read-side sequencer for the `mn_matrix` storage block in the predictor-corrector datapath. On a `start` pulse it walks every element of the stored M×N matrix, or of its transpose, in row-major order. It drives the matrix's `read`/`m_addr`/`n_addr`/`transpose` inputs and returns the elements as a valid/ready stream with a last-element marker. Downstream consumers (dot-product and solver stages) never address the matrix directly.

## Interface
- `DATA_W`, default 32: element width; matches matrix `data_in`/`data_out`.
- `MAX_DIM`, default 128: maximum legal value of `m_dim`/`n_dim`.
- `clk`  input  1: clock; all logic on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `start`  input  1: begin a traversal; sampled only in IDLE.
- `transpose`  input  1: sampled with `start`; selects transposed traversal.
- `m_dim`, `n_dim`  input  32 each: stored matrix dimensions; sampled with `start`.
- `mem_read`  output  1: read strobe to matrix.
- `mem_m_addr`, `mem_n_addr`  output  32 each: logical row/col index to matrix.
- `mem_transpose`  output  1: registered copy of `transpose`.
- `mem_data`  input  DATA_W: matrix `data_out`; valid the cycle after `mem_read`.
- `out_data`  output  DATA_W: element.
- `out_valid`  output  1; `out_ready`  input  1: stream handshake.
- `out_last`  output  1: qualifies the final element.
- `busy`  output  1; `done`  output  1 (one-cycle pulse); `err`  output  1 (one-cycle pulse).

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: on `start`, latch `transpose`. Logical size is R = transpose ? n_dim : m_dim and C = transpose ? m_dim : n_dim.
  - If either dimension is 0 or > MAX_DIM: pulse `err` and `done` next cycle and stay in IDLE. No reads are issued.
  - Otherwise enter RUN with row = col = 0.
- RUN: issue one read per cycle, subject to credit, at `mem_m_addr`=row and `mem_n_addr`=col. Advance col; on col = C−1, wrap col to 0 and increment row. After the read at (R−1, C−1), enter DRAIN.
- Credit rule: a read issues only if fifo_count + inflight − pop < 2, where pop = `out_valid && out_ready` in the current cycle and inflight ≤ 1.
- Returned data enters a 2-entry FIFO; the FIFO head drives `out_data`. `out_last` is set on the entry from the final read.
- DRAIN: wait until the last element is accepted, then pulse `done` the following cycle and return to IDLE.
- `busy` = 1 in RUN and DRAIN. `start` is ignored while busy.
- `mem_read` = 0 and addresses hold their last value whenever no read issues.
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. Reset mid-traversal aborts immediately with no `done`; an in-flight `mem_data` is discarded.
- The block never writes the matrix. The integrator holds matrix `write` low while `busy`.

## Timing
- `start` sampled at edge 0; first `mem_read` in cycle 1; first `out_valid` in cycle 2.
- With `out_ready` held high: one element per cycle. For N = R·C elements, reads occur in cycles 1..N, outputs in cycles 2..N+1, and `done` in cycle N+2.
- Read-to-data latency is 1 cycle. Under back-pressure, at most 2 elements are buffered and no element is dropped or duplicated.
- `out_data`/`out_last` stay stable while `out_valid && !out_ready`.
- `err`/`done` for invalid dimensions pulse in cycle 1.

## Structure
- Shared package `mn_matrix_pkg`: `MAX_DIM`=128, `DATA_W`=32, `ADDR_W`=32, and the state enum {IDLE, RUN, DRAIN}. The `mn_matrix` block and this reader both import it.
- Sub-module `mn_skid_fifo`: 2-entry FIFO with a data+last payload, count output, and push/pop ports.
- Top level contains the FSM, row/col counters (8 bits, zero-extended onto the 32-bit address ports), and credit logic.

## Test plan
- Matrix 2×3 preloaded with value = 10·row+col, transpose=0, ready high → outputs 0,1,2,10,11,12 in cycles 2..7; `out_last` on 12; `done` in cycle 8.
- Same matrix, transpose=1 → addresses (m,n)=(0,0),(0,1),(1,0),(1,1),(2,0),(2,1) with `mem_transpose`=1; outputs 0,10,1,11,2,12.
- 1×4 matrix with `out_ready` toggling 1,0,0,1,… → exactly 4 elements in order; `out_data` stable while stalled; never more than 2 reads ahead of acceptance.
- `m_dim`=0, then `n_dim`=129 → `err` and `done` in cycle 1 with `mem_read` never asserted; `busy` stays 0.
- 3×3 traversal with `reset` asserted after the 4th element → all outputs 0 the next cycle and no `done`; a new `start` then yields all 9 elements from (0,0).
- `start` re-asserted mid-traversal → ignored; element count and order unchanged.
